// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative signed divider.
package div_pkg;

    localparam int DIV_N_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Magnitude of a sign-extended two's complement value. |MIN| comes back as
    // 2^(N-1), which is exact once the caller truncates to N unsigned bits.
    function automatic logic [63:0] abs_n(input logic [63:0] v);
        return v[63] ? (~v + 64'd1) : v;
    endfunction

    // Apply a sign to a zero-extended magnitude; the caller keeps the low N bits.
    function automatic logic [63:0] sign_fix(input logic [63:0] mag, input logic neg);
        return neg ? (~mag + 64'd1) : mag;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference only if it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] dvs,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    logic [N+1:0] shifted;
    logic [N+1:0] trial;

    // Trial subtract; the top bit of the difference decides restore vs keep.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {2'b00, dvs};
        if (trial[N+1]) begin
            rem_out = shifted[N:0];
            q_bit   = 1'b0;
        end else begin
            rem_out = trial[N:0];
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed N-bit divider with start/done handshake. Quotient truncates
// toward zero; remainder carries the dividend's sign. Divide-by-zero and
// MIN/-1 bypass the iteration and are resolved in FIX.
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CW = $clog2(N);

    div_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]   rem_q, rem_d;       // partial remainder
    logic [N-1:0] dvd_q, dvd_d;       // |dividend|, shifts out MSB first, fills with quotient bits
    logic [N-1:0] dvs_q, dvs_d;       // |divisor|
    logic         sgn_dvd_q, sgn_dvd_d;
    logic         sgn_dvs_q, sgn_dvs_d;
    logic         spc_dz_q, spc_dz_d;
    logic         spc_ov_q, spc_ov_d;
    logic [N-1:0] quo_q, quo_d;
    logic [N-1:0] rmd_q, rmd_d;
    logic         dz_out_q, dz_out_d;
    logic         ov_out_q, ov_out_d;

    logic [N:0]   step_rem;
    logic         step_q;
    logic         in_dz;
    logic         in_ov;

    div_step #(.N(N)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[N-1]),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // Special-case detection on the live operands, used only when start is accepted.
    always_comb begin
        in_dz = (divisor == '0);
        in_ov = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
    end

    // Next-state and datapath: capture, iterate, sign fix-up, done pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        sgn_dvd_d = sgn_dvd_q;
        sgn_dvs_d = sgn_dvs_q;
        spc_dz_d  = spc_dz_q;
        spc_ov_d  = spc_ov_q;
        quo_d     = quo_q;
        rmd_d     = rmd_q;
        dz_out_d  = dz_out_q;
        ov_out_d  = ov_out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d     = N'(abs_n(64'(signed'(dividend))));
                    dvs_d     = N'(abs_n(64'(signed'(divisor))));
                    sgn_dvd_d = dividend[N-1];
                    sgn_dvs_d = divisor[N-1];
                    spc_dz_d  = in_dz;
                    spc_ov_d  = in_ov;
                    rem_d     = '0;
                    cnt_d     = CW'(N - 1);
                    state_d   = (in_dz || in_ov) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[N-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (spc_dz_q) begin
                    // dvd_q still holds |dividend| because CALC was skipped.
                    quo_d    = '1;
                    rmd_d    = N'(sign_fix(64'(dvd_q), sgn_dvd_q));
                    dz_out_d = 1'b1;
                    ov_out_d = 1'b0;
                end else if (spc_ov_q) begin
                    quo_d    = {1'b1, {(N-1){1'b0}}};
                    rmd_d    = '0;
                    dz_out_d = 1'b0;
                    ov_out_d = 1'b1;
                end else begin
                    quo_d    = N'(sign_fix(64'(dvd_q), sgn_dvd_q ^ sgn_dvs_q));
                    rmd_d    = N'(sign_fix(64'(rem_q[N-1:0]), sgn_dvd_q));
                    dz_out_d = 1'b0;
                    ov_out_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            sgn_dvd_q <= 1'b0;
            sgn_dvs_q <= 1'b0;
            spc_dz_q  <= 1'b0;
            spc_ov_q  <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dz_out_q  <= 1'b0;
            ov_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            sgn_dvd_q <= sgn_dvd_d;
            sgn_dvs_q <= sgn_dvs_d;
            spc_dz_q  <= spc_dz_d;
            spc_ov_q  <= spc_ov_d;
            quo_q     <= quo_d;
            rmd_q     <= rmd_d;
            dz_out_q  <= dz_out_d;
            ov_out_q  <= ov_out_d;
        end
    end

    // Handshake outputs decode the state; results come only from FIX-written registers.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == DONE);
        quotient    = quo_q;
        remainder   = rmd_q;
        div_by_zero = dz_out_q;
        overflow    = ov_out_q;
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider: directed vector table, handshake and reset
// sequences, and a randomized regression against a 64-bit arithmetic model.
module tb_seq_signed_divider;

    localparam int N = 32;
    localparam logic [N-1:0] MIN_V = 32'h8000_0000;
    localparam logic [N-1:0] MAX_V = 32'h7FFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy, done, div_by_zero, overflow;
    logic [N-1:0] quotient, remainder;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } vec_t;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;

    vec_t tbl[14];
    logic [2*N+1:0] exp_q[$];

    seq_signed_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic plus the two special cases.
    function automatic res_t ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
        res_t   res;
        longint sa;
        longint sb;
        res.dz = 1'b0;
        res.ov = 1'b0;
        if (b == '0) begin
            res.q  = '1;
            res.r  = a;
            res.dz = 1'b1;
        end else if (a == MIN_V && b == '1) begin
            res.q  = MIN_V;
            res.r  = '0;
            res.ov = 1'b1;
        end else begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            res.q = N'(sa / sb);
            res.r = N'(sa % sb);
        end
        return res;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [N-1:0] q, input logic [N-1:0] r,
                                input logic dz, input logic ov, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.ov = ov; v.lat = lat;
        return v;
    endfunction

    function automatic logic [N-1:0] pick_operand();
        logic [N-1:0] corner[7];
        corner[0] = MIN_V; corner[1] = MAX_V; corner[2] = '0; corner[3] = 32'd1;
        corner[4] = '1;    corner[5] = 32'd2; corner[6] = 32'hFFFF_FFFE;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 6)];
        if ($urandom_range(0, 3) == 0) return N'($urandom_range(0, 40)) - 32'd20;
        return N'($urandom);
    endfunction

    // Driver: called in IDLE at #1 after an edge; returns one cycle after done, back in IDLE.
    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output res_t res, output int lat, output logic busy_ok);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        lat      = -1;
        busy_ok  = 1'b1;
        res.q = '0; res.r = '0; res.dz = 1'b0; res.ov = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat    = c;
                res.q  = quotient;
                res.r  = remainder;
                res.dz = div_by_zero;
                res.ov = overflow;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] q, input logic [N-1:0] r,
                            input logic dz, input logic ov, input int lat_exp);
        res_t res;
        int   lat;
        logic busy_ok;
        run_div(a, b, res, lat, busy_ok);
        chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
        chk({tag, " quotient"}, 64'(res.q), 64'(q));
        chk({tag, " remainder"}, 64'(res.r), 64'(r));
        chk({tag, " div_by_zero"}, 64'(res.dz), 64'(dz));
        chk({tag, " overflow"}, 64'(res.ov), 64'(ov));
        chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    endtask

    initial begin
        int           dones;
        int           lat;
        logic [N-1:0] hq, hr;
        res_t         exp_r;
        res_t         res;
        logic         busy_ok;
        logic [2*N+1:0] e;

        // Directed table: values worked out by hand.
        tbl[0]  = mk(32'd1165763863, -32'sd552233, -32'sd2111, 32'd0, 1'b0, 1'b0, N + 2);
        tbl[1]  = mk(-32'sd263875, 32'd125, -32'sd2111, 32'd0, 1'b0, 1'b0, N + 2);
        tbl[2]  = mk(-32'sd2008, 32'd502, -32'sd4, 32'd0, 1'b0, 1'b0, N + 2);
        tbl[3]  = mk(32'd7, -32'sd2, -32'sd3, 32'd1, 1'b0, 1'b0, N + 2);
        tbl[4]  = mk(-32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 1'b0, N + 2);
        tbl[5]  = mk(-32'sd7, -32'sd2, 32'd3, -32'sd1, 1'b0, 1'b0, N + 2);
        tbl[6]  = mk(32'd3, 32'd5, 32'd0, 32'd3, 1'b0, 1'b0, N + 2);
        tbl[7]  = mk(32'd123456789, 32'd0, 32'hFFFF_FFFF, 32'd123456789, 1'b1, 1'b0, 2);
        tbl[8]  = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 2);
        tbl[9]  = mk(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, N + 2);
        tbl[10] = mk(32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 1'b0, N + 2);
        tbl[11] = mk(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0, 1'b0, 1'b0, N + 2);
        tbl[12] = mk(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, N + 2);
        tbl[13] = mk(-32'sd5, 32'd0, 32'hFFFF_FFFF, -32'sd5, 1'b1, 1'b0, 2);

        // Reset state.
        #12;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset quotient", 64'(quotient), 64'd0);
        chk("reset remainder", 64'(remainder), 64'd0);
        chk("reset flags", 64'({div_by_zero, overflow}), 64'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                     tbl[i].dz, tbl[i].ov, tbl[i].lat);
        end

        // Handshake: start held high with changing operands through busy and DONE.
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk); #1;
        dones = 0;
        lat   = -1;
        hq    = '0;
        hr    = '0;
        for (int c = 1; c <= 90; c++) begin
            dividend = N'($urandom);
            divisor  = N'($urandom);
            if (lat > 0 && c == lat + 1) start = 1'b0;
            if (done === 1'b1) begin
                dones++;
                if (lat < 0) begin
                    lat = c;
                    hq  = quotient;
                    hr  = remainder;
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("hold done count", 64'(dones), 64'd1);
        chk("hold latency", 64'(lat), 64'(N + 2));
        chk("hold quotient", 64'(hq), 64'd14);
        chk("hold remainder", 64'(hr), 64'd2);

        // Reset in CALC cycle 10 aborts the operation.
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre-reset busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort quotient", 64'(quotient), 64'd0);
        chk("abort remainder", 64'(remainder), 64'd0);
        chk("abort flags", 64'({div_by_zero, overflow}), 64'd0);
        #2 rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        chk("abort no done", 64'(dones), 64'd0);
        check_op("post-reset", -32'sd1000, 32'd3, -32'sd333, -32'sd1, 1'b0, 1'b0, N + 2);

        // Randomized regression through an expected queue.
        for (int i = 0; i < 1200; i++) begin
            logic [N-1:0] a, b;
            a = pick_operand();
            b = pick_operand();
            exp_r = ref_div(a, b);
            exp_q.push_back({exp_r.q, exp_r.r, exp_r.dz, exp_r.ov});
            run_div(a, b, res, lat, busy_ok);
            e = exp_q.pop_front();
            chk($sformatf("rnd%0d %h/%h result", i, a, b),
                64'({res.q, res.r}), 64'({e[2*N+1:N+2], e[N+1:2]}));
            chk($sformatf("rnd%0d %h/%h flags", i, a, b),
                64'({res.dz, res.ov}), 64'(e[1:0]));
            chk($sformatf("rnd%0d latency", i), 64'(lat),
                64'((e[1] || e[0]) ? 2 : N + 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
